alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor of the 4-bit combinational ALU/display block.
- Operation select cycles on a button edge; operands are captured on a start request.
- Result and flags are registered; a multi-cycle double-dabble converts the signed magnitude to BCD for the seg7 decoders.
- Sits between the NVBoard switches/buttons and the existing seg instances. Handshake is start/busy/done.

Parameters:
- WIDTH, 8, operand/result width (>=4).
- DIGITS, 3, BCD digits of magnitude; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high. One clock domain; reset is asynchronous and active-high.
- en  in  1  block enable; 0 aborts and clears.
- op_btn  in  1  raw button level; each rising edge advances op.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  out  3  current operation select.
- busy  out  1  high in EXEC/CONV/DONE.
- done  out  1  one-cycle pulse when result, flags and bcd are valid.
- result  out  WIDTH  registered result.
- CF, ZF, SF, OF  out  1 each  registered flags.
- bcd  out  4*DIGITS  magnitude, BCD, digit 0 in [3:0].
- neg  out  1  sign for display (1 = show minus).

Behaviour:
- Reset (async): state=IDLE; op=0; result=0; all flags=0; bcd=0; neg=0; busy=0; done=0; button synchroniser=0.
- op_btn path:
  - Two-flop synchroniser, then rising-edge detect.
  - Each edge increments op modulo 8 (111->000). A held level gives one increment.
  - Active in all states. The operation in flight uses the op latched at start.
- FSM IDLE:
  - start&&en -> EXEC; latch a, b, op.
  - start while busy is ignored.
- FSM EXEC (1 cycle): compute and register result/flags, load the magnitude shifter, -> CONV.
- FSM CONV (exactly WIDTH cycles): shift-add-3 double-dabble, -> DONE.
- FSM DONE (1 cycle): bcd/neg updated, done=1, -> IDLE.
- Latency: done is high in the cycle following the (WIDTH+1)th rising edge after the edge that sampled start. result/flags are valid from EXEC exit onward and are held until the next EXEC.
- Ops (mod 2^WIDTH):
  - 000 add: a+b; CF=carry out; OF=(a[M]==b[M])&&(r[M]!=a[M]); SF=r[M].
  - 001 sub: a+~b+1; CF=carry out (1 = no borrow); OF=(a[M]!=b[M])&&(r[M]!=a[M]); SF=r[M].
  - 010 not: ~a; CF=OF=0; SF=r[M].
  - 011 and, 100 or, 101 xor: CF=OF=SF=0.
  - 110 signed a<b: r={0..,lt}; CF=OF=SF=0.
  - 111 a==b: r={0..,eq}; CF=OF=SF=0.
  - M=WIDTH-1. ZF=(r==0) for all ops.
- Display magnitude:
  - Ops 000-010: mag=SF?-r:r, neg=SF.
  - Other ops: mag=r, neg=0.
  - -2^(WIDTH-1) yields mag 2^(WIDTH-1), handled unsigned.
- en=0: next edge -> IDLE, aborting any operation. result/flags/bcd/neg=0, busy=0, done=0. op is still updated by button edges.
- Reset mid-operation: immediate IDLE with reset values; no done pulse.

Optional Feature:
- ALU_SAT_EN defined: add/sub saturate on OF=1.
  - Positive overflow -> 0111..1; negative -> 1000..0.
  - OF still reports 1; SF/ZF are computed from the saturated result; CF is unchanged (raw carry).
- Undefined: wrap-around arithmetic as above.

Test Plan:
- WIDTH=8, op=000, a=0x64, b=0x1B, start -> done 9 cycles after the start edge; result=0x7F; CF=ZF=SF=OF=0; bcd=0x127; neg=0.
- op=000, a=0x7F, b=0x01 -> result=0x80, OF=1, SF=1, CF=0, bcd=0x128, neg=1. With ALU_SAT_EN: result=0x7F, OF=1, SF=0, bcd=0x127, neg=0.
- op=001, a=0x05, b=0x09 -> result=0xFC, SF=1, CF=0, OF=0, bcd=0x004, neg=1. Then a=b=0x33 -> result=0, ZF=1, CF=1.
- From reset, 9 op_btn pulses -> op=001; op_btn held high 20 cycles -> exactly one increment; a pulse during CONV does not alter the in-flight result.
- op=110, a=0xFF, b=0x01 -> result=0x01, ZF=0. op=111, a=b=0x3C -> result=0x01. op=111, a=0x3C, b=0x3D -> result=0, ZF=1.
- rst asserted mid-CONV -> same cycle busy=0, done=0, result=0, op=0; en dropped mid-CONV -> IDLE next edge, no done pulse; start during busy -> ignored.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with button-cycled op select and a multi-cycle double-dabble BCD stage.
// Optional `ALU_SAT_EN: add/sub saturate on signed overflow instead of wrapping.
module alu_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  op_btn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic [2:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  CF,
    output logic                  ZF,
    output logic                  SF,
    output logic                  OF,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);
    localparam int unsigned M  = WIDTH - 1;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d, opx_q, opx_d;
    logic [1:0]       sync_q, sync_d;
    logic             btn_prev_q, btn_prev_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, bin_q, bin_d;
    logic             cf_q, cf_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic [BW-1:0]    bcd_q, bcd_d, work_q, work_d;
    logic             neg_q, neg_d, negp_q, negp_d, busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r, alu_mag;
    logic             alu_cf, alu_of, alu_sf, alu_zf, rise;
    logic [BW-1:0]    adj, shifted;

    // Combinational ALU on the operands/op latched at start
    always_comb begin
        sum    = '0;
        alu_r  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case (opx_q)
            3'd0: begin
                sum    = {1'b0, a_q} + {1'b0, b_q};
                alu_r  = sum[WIDTH-1:0];
                alu_cf = sum[WIDTH];
                alu_of = (a_q[M] == b_q[M]) && (alu_r[M] != a_q[M]);
            end
            3'd1: begin
                sum    = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
                alu_r  = sum[WIDTH-1:0];
                alu_cf = sum[WIDTH];
                alu_of = (a_q[M] != b_q[M]) && (alu_r[M] != a_q[M]);
            end
            3'd2:    alu_r = ~a_q;
            3'd3:    alu_r = a_q & b_q;
            3'd4:    alu_r = a_q | b_q;
            3'd5:    alu_r = a_q ^ b_q;
            3'd6:    alu_r = {{M{1'b0}}, $signed(a_q) < $signed(b_q)};
            default: alu_r = {{M{1'b0}}, a_q == b_q};
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign of a for both add and sub
        if (alu_of) begin
            alu_r = a_q[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
        end
`else
`endif
        alu_sf  = (opx_q <= 3'd2) ? alu_r[M] : 1'b0;
        alu_zf  = (alu_r == '0);
        alu_mag = alu_sf ? (~alu_r + WIDTH'(1)) : alu_r;
    end

    // One double-dabble step: add 3 to digits >= 5, then shift in the next bit
    always_comb begin
        adj = work_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[BW-2:0], bin_q[M]};
    end

    assign rise = sync_q[1] & ~btn_prev_q;

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], op_btn};
        btn_prev_d = sync_q[1];
        op_d       = op_q + 3'(rise);
        opx_d      = opx_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        cf_d       = cf_q;
        zf_d       = zf_q;
        sf_d       = sf_q;
        of_d       = of_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        negp_d     = negp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bin_d      = bin_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        if (!en) begin
            state_d  = S_IDLE;
            result_d = '0;
            cf_d     = 1'b0;
            zf_d     = 1'b0;
            sf_d     = 1'b0;
            of_d     = 1'b0;
            bcd_d    = '0;
            neg_d    = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        opx_d   = op_q;
                        busy_d  = 1'b1;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_d = alu_r;
                    cf_d     = alu_cf;
                    zf_d     = alu_zf;
                    sf_d     = alu_sf;
                    of_d     = alu_of;
                    negp_d   = alu_sf;
                    bin_d    = alu_mag;
                    work_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_CONV;
                end
                S_CONV: begin
                    work_d = shifted;
                    bin_d  = bin_q << 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bcd_d   = shifted;
                        neg_d   = negp_q;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            btn_prev_q <= 1'b0;
            op_q       <= '0;
            opx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            cf_q       <= 1'b0;
            zf_q       <= 1'b0;
            sf_q       <= 1'b0;
            of_q       <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            negp_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bin_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            btn_prev_q <= btn_prev_d;
            op_q       <= op_d;
            opx_q      <= opx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            cf_q       <= cf_d;
            zf_q       <= zf_d;
            sf_q       <= sf_d;
            of_q       <= of_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            negp_q     <= negp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
        end
    end

    assign op     = op_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign CF     = cf_q;
    assign ZF     = zf_q;
    assign SF     = sf_q;
    assign OF     = of_q;
    assign bcd    = bcd_q;
    assign neg    = neg_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8, DIGITS=3.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst, en, op_btn, start;
    logic [7:0]  a, b, result;
    logic [2:0]  op;
    logic        busy, done, cf, zf, sf, of, neg;
    logic [11:0] bcd;

    typedef struct packed {
        logic [7:0]  r;
        logic [3:0]  f;
        logic [11:0] bcd;
        logic        neg;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_op = 3'd0;

    alu_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .en(en), .op_btn(op_btn), .start(start),
        .a(a), .b(b), .op(op), .busy(busy), .done(done), .result(result),
        .CF(cf), .ZF(zf), .SF(sf), .OF(of), .bcd(bcd), .neg(neg)
    );

    always #5 clk = ~clk;

    // Reference model in integer arithmetic; f = {CF, ZF, SF, OF}
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ux, uy, sx, sy, full, sres, mag;
        logic c, v, s;
        logic [7:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        c = 1'b0;
        v = 1'b0;
        full = 0;
        sres = 0;
        case (o)
            3'd0: begin full = ux + uy;       sres = sx + sy; end
            3'd1: begin full = ux + (255 - uy) + 1; sres = sx - sy; end
            default: ;
        endcase
        case (o)
            3'd0, 3'd1: begin
                r = 8'(full);
                c = full > 255;
                v = (sres > 127) || (sres < -128);
`ifdef ALU_SAT_EN
                if (v) r = (sres > 127) ? 8'h7F : 8'h80;
`endif
            end
            3'd2: r = ~x;
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = (sx < sy) ? 8'd1 : 8'd0;
            default: r = (ux == uy) ? 8'd1 : 8'd0;
        endcase
        s = (o <= 3'd2) && (int'(r) > 127);
        mag = s ? 256 - int'(r) : int'(r);
        e.r   = r;
        e.f   = {c, r == 8'd0, s, v};
        e.bcd = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
        e.neg = s;
        return e;
    endfunction

    // Pops the scoreboard whenever the DUT signals done
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 result=%h, required no done", result);
            end else begin
                e = sb.pop_front();
                if (result !== e.r) begin
                    errors++;
                    $display("FAIL result: got %h, required %h", result, e.r);
                end
                checks++;
                if ({cf, zf, sf, of} !== e.f) begin
                    errors++;
                    $display("FAIL flags_CZSO: got %b, required %b", {cf, zf, sf, of}, e.f);
                end
                checks++;
                if (bcd !== e.bcd) begin
                    errors++;
                    $display("FAIL bcd: got %h, required %h", bcd, e.bcd);
                end
                checks++;
                if (neg !== e.neg) begin
                    errors++;
                    $display("FAIL neg: got %b, required %b", neg, e.neg);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input bit expect_done);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        if (expect_done) sb.push_back(model(exp_op, x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit seen);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic pulse_btn();
        op_btn = 1'b1;
        repeat (2) @(negedge clk);
        op_btn = 1'b0;
        repeat (2) @(negedge clk);
        exp_op = exp_op + 3'd1;
    endtask

    task automatic set_op(input logic [2:0] t);
        while (exp_op != t) pulse_btn();
        checks++;
        if (op !== t) begin
            errors++;
            $display("FAIL op_select: got %0d, required %0d", op, t);
        end
    endtask

    task automatic run(input logic [7:0] x, input logic [7:0] y, input string name);
        int lat;
        bit seen;
        issue(x, y, 1'b1);
        wait_done(lat, seen);
        checks++;
        if (!seen || lat != 9) begin
            errors++;
            $display("FAIL latency_%s: got seen=%0d after %0d cycles, required done at 9", name, seen, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; op_btn = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({op, busy, done, result, cf, zf, sf, of, bcd, neg} !== '0) begin
            errors++;
            $display("FAIL reset_state: got op=%0d busy=%b done=%b result=%h flags=%b bcd=%h neg=%b, required all 0",
                     op, busy, done, result, {cf, zf, sf, of}, bcd, neg);
        end
        rst = 1'b0;
        exp_op = 3'd0;
        @(negedge clk);
    endtask

    task automatic test_add();
        set_op(3'd0);
        run(8'h64, 8'h1B, "add_127");
        run(8'h7F, 8'h01, "add_ovf");
        run(8'hFF, 8'h01, "add_carry");
        run(8'h80, 8'h80, "add_negovf");
    endtask

    task automatic test_sub();
        set_op(3'd1);
        run(8'h05, 8'h09, "sub_neg");
        run(8'h33, 8'h33, "sub_zero");
        run(8'h80, 8'h01, "sub_ovf");
    endtask

    task automatic test_logic();
        set_op(3'd2);
        run(8'h00, 8'h00, "not");
        set_op(3'd3);
        run(8'hF0, 8'h3C, "and");
        set_op(3'd4);
        run(8'hA0, 8'h05, "or");
        set_op(3'd5);
        run(8'hFF, 8'h0F, "xor");
    endtask

    task automatic test_cmp();
        set_op(3'd6);
        run(8'hFF, 8'h01, "lt_true");
        run(8'h01, 8'hFF, "lt_false");
        set_op(3'd7);
        run(8'h3C, 8'h3C, "eq_true");
        run(8'h3C, 8'h3D, "eq_false");
    endtask

    task automatic test_op_btn();
        int lat;
        bit seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_op = 3'd0;
        for (int i = 0; i < 9; i++) pulse_btn();
        checks++;
        if (op !== 3'd1) begin
            errors++;
            $display("FAIL op_wrap_9_pulses: got %0d, required 1", op);
        end
        op_btn = 1'b1;
        repeat (20) @(negedge clk);
        op_btn = 1'b0;
        repeat (3) @(negedge clk);
        exp_op = exp_op + 3'd1;
        checks++;
        if (op !== 3'd2) begin
            errors++;
            $display("FAIL op_held: got %0d, required 2", op);
        end
        // op 2 (not) latched; a press mid-conversion must not change it
        issue(8'h05, 8'h00, 1'b1);
        @(negedge clk);
        pulse_btn();
        wait_done(lat, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL btn_in_flight_done: got no done, required done");
        end
        @(negedge clk);
        checks++;
        if (op !== 3'd3) begin
            errors++;
            $display("FAIL btn_in_flight_op: got %0d, required 3", op);
        end
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        set_op(3'd0);
        issue(8'h64, 8'h1B, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || result !== 8'h7F) begin
            errors++;
            $display("FAIL pre_reset_conv: got busy=%b result=%h, required busy=1 result=7f", busy, result);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, op} !== '0) begin
            errors++;
            $display("FAIL reset_mid_conv: got busy=%b done=%b result=%h op=%0d, required all 0", busy, done, result, op);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_op = 3'd0;
        repeat (12) @(negedge clk);

        issue(8'h64, 8'h1B, 1'b0);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, cf, zf, sf, of, bcd, neg} !== '0) begin
            errors++;
            $display("FAIL en_abort: got busy=%b done=%b result=%h flags=%b bcd=%h neg=%b, required all 0",
                     busy, done, result, {cf, zf, sf, of}, bcd, neg);
        end
        en = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit seen;
        set_op(3'd0);
        issue(8'h10, 8'h20, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_while_busy: got no done, required one done");
        end
        repeat (15) @(negedge clk);
        run(8'h09, 8'hF6, "after_busy");
        repeat (15) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_cmp();
        test_op_btn();
        test_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
